// File: rtl/mem_arb_pkg.sv
// Shared widths, owner encoding and address helper for mem_arbiter.
package mem_arb_pkg;

   localparam int MEM_AW   = 32;
   localparam int MEM_DW   = 32;
   localparam int MEM_MW   = MEM_DW / 8;
   localparam int STARVE_W = 4;

   // Requester that issued the strobed read whose data returns next cycle.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_LS   = 2'd2
   } owner_t;

   function automatic logic [MEM_AW-1:0] word_align(input logic [MEM_AW-1:0] addr);
      return {addr[MEM_AW-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares one synchronous single-port memory between instruction fetch and the LSU.
// Define MEM_ARB_RR_EN for round-robin; otherwise LSU has priority with a fetch starvation guard.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              resetn,

   input  logic              ifReq,
   input  logic [MEM_AW-1:0] ifAddr,
   output logic              ifGnt,
   output logic              ifRValid,
   output logic [MEM_DW-1:0] ifRData,

   input  logic              lsReq,
   input  logic [MEM_AW-1:0] lsAddr,
   input  logic              lsRstrb,
   input  logic [MEM_DW-1:0] lsWData,
   input  logic [MEM_MW-1:0] lsWMask,
   output logic              lsGnt,
   output logic              lsRValid,
   output logic [MEM_DW-1:0] lsRData,

   output logic [MEM_AW-1:0] memAddr,
   output logic              memRstrb,
   output logic [MEM_DW-1:0] memWData,
   output logic [MEM_MW-1:0] memWMask,
   input  logic [MEM_DW-1:0] memRData
);

   logic              if_win;
   logic              ls_win;
   owner_t            rd_owner;
   owner_t            rd_owner_nxt;
   logic [MEM_AW-1:0] addr_q;
   logic [MEM_DW-1:0] wdata_q;

`ifdef MEM_ARB_RR_EN
   // Set after a fetch grant, so the LSU wins the next contention.
   logic prefer_ls;

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      if_win = ifReq;
      ls_win = lsReq;
      if (ifReq && lsReq) begin
         if_win = !prefer_ls;
         ls_win = prefer_ls;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         prefer_ls <= 1'b0;
      end else if (ifGnt) begin
         prefer_ls <= 1'b1;
      end else if (lsGnt) begin
         prefer_ls <= 1'b0;
      end
   end
`else
   localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

   logic [STARVE_W-1:0] starve_cnt;
   logic                starved;

   assign starved = (starve_cnt == LIMIT);

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      if_win = ifReq;
      ls_win = lsReq;
      if (ifReq && lsReq) begin
         if_win = starved;
         ls_win = !starved;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         starve_cnt <= '0;
      end else if (!ifReq || ifGnt) begin
         starve_cnt <= '0;
      end else if (!starved) begin
         starve_cnt <= starve_cnt + STARVE_W'(1);
      end
   end
`endif

   // Grants are gated by reset so nothing reaches memory while resetn is low.
   assign ifGnt = resetn & if_win;
   assign lsGnt = resetn & ls_win;

   always_comb begin
      memAddr  = addr_q;
      memWData = wdata_q;
      memRstrb = 1'b0;
      memWMask = '0;
      if (ifGnt) begin
         memAddr  = word_align(ifAddr);
         memRstrb = 1'b1;
      end else if (lsGnt) begin
         memAddr  = lsAddr;
         memRstrb = lsRstrb;
         memWData = lsWData;
         memWMask = lsWMask;
      end
   end

   always_comb begin
      rd_owner_nxt = OWN_NONE;
      if (ifGnt) begin
         rd_owner_nxt = OWN_IF;
      end else if (lsGnt && lsRstrb) begin
         rd_owner_nxt = OWN_LS;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_owner <= OWN_NONE;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         rd_owner <= rd_owner_nxt;
         if (ifGnt || lsGnt) begin
            addr_q  <= memAddr;
            wdata_q <= memWData;
         end
      end
   end

   assign ifRValid = (rd_owner == OWN_IF);
   assign lsRValid = (rd_owner == OWN_LS);
   assign ifRData  = ifRValid ? memRData : '0;
   assign lsRData  = lsRValid ? memRData : '0;

`ifndef SYNTHESIS
   a_one_grant : assert property (@(posedge clk) disable iff (!resetn) !(ifGnt && lsGnt));
   a_one_valid : assert property (@(posedge clk) disable iff (!resetn) !(ifRValid && lsRValid));
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter against a behavioural arbitration/memory model.
`timescale 1ns/1ps
module tb_mem_arbiter;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        resetn;
   logic        ifReq, lsReq, lsRstrb;
   logic [31:0] ifAddr, lsAddr, lsWData;
   logic [3:0]  lsWMask;
   logic        ifGnt, ifRValid, lsGnt, lsRValid, memRstrb;
   logic [31:0] ifRData, lsRData, memAddr, memWData, memRData;
   logic [3:0]  memWMask;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .resetn(resetn),
      .ifReq(ifReq), .ifAddr(ifAddr), .ifGnt(ifGnt), .ifRValid(ifRValid), .ifRData(ifRData),
      .lsReq(lsReq), .lsAddr(lsAddr), .lsRstrb(lsRstrb), .lsWData(lsWData), .lsWMask(lsWMask),
      .lsGnt(lsGnt), .lsRValid(lsRValid), .lsRData(lsRData),
      .memAddr(memAddr), .memRstrb(memRstrb), .memWData(memWData), .memWMask(memWMask),
      .memRData(memRData)
   );

   function automatic logic [31:0] init_word(input int i);
      logic [7:0] b;
      b = 8'(i);
      return {b, 8'hA5, ~b, b ^ 8'h3C};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] m);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   // Synchronous read-before-write RAM, 256 words.
   logic [31:0] ram [256];
   bit          ram_written [256];
   logic [7:0]  ram_idx;
   logic [31:0] ram_cur;
   assign ram_idx = memAddr[9:2];
   assign ram_cur = ram_written[ram_idx] ? ram[ram_idx] : init_word(int'(ram_idx));

   always @(posedge clk) begin
      if (memRstrb) memRData <= ram_cur;
      if (memWMask != 4'h0) begin
         ram[ram_idx]         <= merge(ram_cur, memWData, memWMask);
         ram_written[ram_idx] <= 1'b1;
      end
   end

   // Reference model state
   logic [31:0] model_mem [256];
   int          starve;
   bit          last_if;
   bit          pend_if, pend_ls;
   logic [31:0] pend_if_data, pend_ls_data;
   logic [31:0] last_addr, last_wdata;

   logic        e_if_gnt, e_ls_gnt, e_rstrb, e_if_rv, e_ls_rv;
   logic [31:0] e_addr, e_wdata, e_if_rd, e_ls_rd;
   logic [3:0]  e_wmask;

   task automatic model_reset();
      starve     = 0;
      last_if    = 1'b0;
      pend_if    = 1'b0;
      pend_ls    = 1'b0;
      last_addr  = 32'h0;
      last_wdata = 32'h0;
      e_if_gnt   = 1'b0;
      e_ls_gnt   = 1'b0;
   endtask

   task automatic predict();
      e_if_gnt = 1'b0;
      e_ls_gnt = 1'b0;
      if (ifReq && lsReq) begin
`ifdef MEM_ARB_RR_EN
         if (last_if) e_ls_gnt = 1'b1;
         else         e_if_gnt = 1'b1;
`else
         if (starve >= LIMIT) e_if_gnt = 1'b1;
         else                 e_ls_gnt = 1'b1;
`endif
      end else begin
         e_if_gnt = ifReq;
         e_ls_gnt = lsReq;
      end
      e_addr  = last_addr;
      e_wdata = last_wdata;
      e_rstrb = 1'b0;
      e_wmask = 4'h0;
      if (e_if_gnt) begin
         e_addr  = ifAddr & ~32'h3;
         e_rstrb = 1'b1;
      end else if (e_ls_gnt) begin
         e_addr  = lsAddr;
         e_rstrb = lsRstrb;
         e_wdata = lsWData;
         e_wmask = lsWMask;
      end
      e_if_rv = pend_if;
      e_ls_rv = pend_ls;
      e_if_rd = pend_if ? pend_if_data : 32'h0;
      e_ls_rd = pend_ls ? pend_ls_data : 32'h0;
   endtask

   task automatic commit();
      int idx;
      idx     = int'(e_addr[9:2]);
      pend_if = e_if_gnt;
      pend_ls = e_ls_gnt && lsRstrb;
      if (pend_if) pend_if_data = model_mem[idx];
      if (pend_ls) pend_ls_data = model_mem[idx];
      model_mem[idx] = merge(model_mem[idx], e_wdata, e_wmask);
      if (e_if_gnt || e_ls_gnt) begin
         last_addr  = e_addr;
         last_wdata = e_wdata;
      end
      if (ifReq && !e_if_gnt) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
      else                    starve = 0;
      if (e_if_gnt)      last_if = 1'b1;
      else if (e_ls_gnt) last_if = 1'b0;
   endtask

   task automatic begin_cycle();
      predict();
      @(negedge clk);
   endtask

   task automatic end_cycle();
      commit();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ifReq   = 1'b0;
      lsReq   = 1'b0;
      lsRstrb = 1'b0;
      lsWMask = 4'h0;
   endtask

   task automatic test_reset();
      resetn  = 1'b0;
      ifReq   = 1'b1;
      ifAddr  = 32'h0000_0104;
      lsReq   = 1'b1;
      lsAddr  = 32'h0000_0020;
      lsRstrb = 1'b1;
      lsWData = 32'h1234_5678;
      lsWMask = 4'hF;
      repeat (2) @(negedge clk);
      total++;
      if ({ifGnt, lsGnt, ifRValid, lsRValid, memRstrb} !== 5'b0) begin
         bad++;
         $display("FAIL reset_ctrl got=%b want=00000", {ifGnt, lsGnt, ifRValid, lsRValid, memRstrb});
      end
      total++;
      if (memWMask !== 4'h0) begin
         bad++;
         $display("FAIL reset_wmask got=%h want=0", memWMask);
      end
      total++;
      if (memAddr !== 32'h0 || memWData !== 32'h0) begin
         bad++;
         $display("FAIL reset_addr_wdata got=%h/%h want=0/0", memAddr, memWData);
      end
      total++;
      if (ifRData !== 32'h0 || lsRData !== 32'h0) begin
         bad++;
         $display("FAIL reset_rdata got=%h/%h want=0/0", ifRData, lsRData);
      end
      @(posedge clk);
      #1;
      idle();
      resetn = 1'b1;
      model_reset();
   endtask

   task automatic test_fetch_only();
      logic [31:0] want;
      want = init_word(32'h40);
      for (int k = 0; k < 4; k++) begin
         ifReq  = (k < 3);
         ifAddr = 32'h0000_0100;
         begin_cycle();
         total++;
         if (ifGnt !== (k < 3) || lsGnt !== 1'b0) begin
            bad++;
            $display("FAIL fetch_gnt c%0d got=%b%b want=%b0", k, ifGnt, lsGnt, (k < 3));
         end
         if (k < 3) begin
            total++;
            if (memAddr !== 32'h100 || memRstrb !== 1'b1 || memWMask !== 4'h0) begin
               bad++;
               $display("FAIL fetch_port c%0d got=%h/%b/%h want=100/1/0", k, memAddr, memRstrb, memWMask);
            end
         end
         if (k >= 1) begin
            total++;
            if (ifRValid !== 1'b1 || ifRData !== want) begin
               bad++;
               $display("FAIL fetch_data c%0d got=%b/%h want=1/%h", k, ifRValid, ifRData, want);
            end
         end
         end_cycle();
      end
   endtask

   task automatic test_write_read();
      logic [31:0] old, want;
      old  = init_word(8);
      want = {old[31:16], 16'hCCDD};
      lsReq = 1'b1; lsAddr = 32'h20; lsRstrb = 1'b0; lsWMask = 4'b0011; lsWData = 32'hAABB_CCDD;
      begin_cycle();
      total++;
      if (lsGnt !== 1'b1 || memWMask !== 4'b0011 || memRstrb !== 1'b0 || memWData !== 32'hAABBCCDD) begin
         bad++;
         $display("FAIL wr_port got=%b/%h/%b/%h want=1/3/0/aabbccdd", lsGnt, memWMask, memRstrb, memWData);
      end
      end_cycle();
      lsRstrb = 1'b1; lsWMask = 4'h0;
      begin_cycle();
      total++;
      if (lsGnt !== 1'b1 || lsRValid !== 1'b0) begin
         bad++;
         $display("FAIL wr_no_rvalid got=%b/%b want=1/0", lsGnt, lsRValid);
      end
      end_cycle();
      idle();
      begin_cycle();
      total++;
      if (lsRValid !== 1'b1 || lsRData !== want) begin
         bad++;
         $display("FAIL rd_after_wr got=%b/%h want=1/%h", lsRValid, lsRData, want);
      end
      end_cycle();
      begin_cycle();
      total++;
      if (lsRValid !== 1'b0) begin
         bad++;
         $display("FAIL rd_single_pulse got=%b want=0", lsRValid);
      end
      end_cycle();
   endtask

   task automatic test_noop();
      lsReq = 1'b1; lsAddr = 32'h44; lsRstrb = 1'b0; lsWMask = 4'h0; lsWData = 32'hDEAD_BEEF;
      begin_cycle();
      total++;
      if (lsGnt !== 1'b1 || memRstrb !== 1'b0 || memWMask !== 4'h0) begin
         bad++;
         $display("FAIL noop_port got=%b/%b/%h want=1/0/0", lsGnt, memRstrb, memWMask);
      end
      end_cycle();
      idle();
      begin_cycle();
      total++;
      if (lsRValid !== 1'b0 || ifRValid !== 1'b0) begin
         bad++;
         $display("FAIL noop_rvalid got=%b/%b want=0/0", lsRValid, ifRValid);
      end
      end_cycle();
   endtask

   task automatic test_contention();
      logic prev_if;
      prev_if = 1'b0;
      idle();
      begin_cycle();
      end_cycle();
      ifReq = 1'b1; ifAddr = 32'h80;
      lsReq = 1'b1; lsAddr = 32'h90; lsRstrb = 1'b1; lsWMask = 4'h0;
      for (int k = 0; k < 16; k++) begin
         if (k == 15) idle();
         begin_cycle();
         if (k < 15) begin
            total++;
`ifdef MEM_ARB_RR_EN
            if ((ifGnt ^ lsGnt) !== 1'b1 || (k > 0 && ifGnt !== !prev_if)) begin
               bad++;
               $display("FAIL rr_alternate c%0d got=%b%b prev_if=%b", k, ifGnt, lsGnt, prev_if);
            end
`else
            if (ifGnt !== (k % 5 == 4) || lsGnt !== (k % 5 != 4)) begin
               bad++;
               $display("FAIL fixed_starve c%0d got=%b%b want=%b%b", k, ifGnt, lsGnt,
                        (k % 5 == 4), (k % 5 != 4));
            end
`endif
            prev_if = ifGnt;
         end
         total++;
         if (ifRValid !== e_if_rv || lsRValid !== e_ls_rv || ifRData !== e_if_rd || lsRData !== e_ls_rd) begin
            bad++;
            $display("FAIL cont_steer c%0d got=%b%b %h/%h want=%b%b %h/%h", k, ifRValid, lsRValid,
                     ifRData, lsRData, e_if_rv, e_ls_rv, e_if_rd, e_ls_rd);
         end
         end_cycle();
      end
   endtask

   task automatic test_reset_inflight();
      idle();
      lsReq = 1'b1; lsAddr = 32'h30; lsRstrb = 1'b1;
      begin_cycle();
      total++;
      if (lsGnt !== 1'b1 || memRstrb !== 1'b1) begin
         bad++;
         $display("FAIL inflight_gnt got=%b/%b want=1/1", lsGnt, memRstrb);
      end
      end_cycle();
      idle();
      resetn = 1'b0;
      model_reset();
      #1;
      total++;
      if ({ifGnt, lsGnt, ifRValid, lsRValid, memRstrb, memWMask} !== 9'b0 || memAddr !== 32'h0) begin
         bad++;
         $display("FAIL inflight_reset got=%b%b%b%b%b%h/%h want=0", ifGnt, lsGnt, ifRValid, lsRValid,
                  memRstrb, memWMask, memAddr);
      end
      @(posedge clk);
      #1;
      resetn = 1'b1;
      begin_cycle();
      total++;
      if (lsRValid !== 1'b0 || lsRData !== 32'h0) begin
         bad++;
         $display("FAIL inflight_dropped got=%b/%h want=0/0", lsRValid, lsRData);
      end
      end_cycle();
      ifReq = 1'b1; ifAddr = 32'h104;
      begin_cycle();
      total++;
      if (ifGnt !== 1'b1 || memAddr !== 32'h104 || memRstrb !== 1'b1) begin
         bad++;
         $display("FAIL post_reset_gnt got=%b/%h/%b want=1/104/1", ifGnt, memAddr, memRstrb);
      end
      end_cycle();
      idle();
      begin_cycle();
      total++;
      if (ifRValid !== 1'b1 || ifRData !== e_if_rd || e_if_rd !== model_mem[32'h41]) begin
         bad++;
         $display("FAIL post_reset_data got=%b/%h want=1/%h", ifRValid, ifRData, model_mem[32'h41]);
      end
      end_cycle();
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         if (!(ifReq && !e_if_gnt && $urandom_range(7) != 0)) begin
            ifReq  = ($urandom_range(9) < 6);
            ifAddr = {22'h0, 8'($urandom), 2'($urandom)};
         end
         if (!(lsReq && !e_ls_gnt && $urandom_range(7) != 0)) begin
            lsReq   = ($urandom_range(9) < 6);
            lsAddr  = {22'h0, 8'($urandom_range(31)), 2'($urandom)};
            lsRstrb = 1'($urandom);
            lsWMask = 4'($urandom);
            lsWData = $urandom;
         end
         begin_cycle();
         total++;
         if (ifGnt !== e_if_gnt || lsGnt !== e_ls_gnt) begin
            bad++;
            $display("FAIL rnd_gnt c%0d got=%b%b want=%b%b", k, ifGnt, lsGnt, e_if_gnt, e_ls_gnt);
         end
         total++;
         if (memAddr !== e_addr || memRstrb !== e_rstrb || memWData !== e_wdata || memWMask !== e_wmask) begin
            bad++;
            $display("FAIL rnd_port c%0d got=%h/%b/%h/%h want=%h/%b/%h/%h", k, memAddr, memRstrb,
                     memWData, memWMask, e_addr, e_rstrb, e_wdata, e_wmask);
         end
         total++;
         if (ifRValid !== e_if_rv || lsRValid !== e_ls_rv || ifRData !== e_if_rd || lsRData !== e_ls_rd) begin
            bad++;
            $display("FAIL rnd_read c%0d got=%b%b %h/%h want=%b%b %h/%h", k, ifRValid, lsRValid,
                     ifRData, lsRData, e_if_rv, e_ls_rv, e_if_rd, e_ls_rd);
         end
         end_cycle();
      end
      idle();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) model_mem[i] = init_word(i);
      model_reset();
      test_reset();
      test_fetch_only();
      test_write_read();
      test_noop();
      test_contention();
      test_reset_inflight();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
